alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_flag_gen.sv | 24 ++
 rtl/alu_result_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: flag struct, flag bit positions, buffer states.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package alu_pkg;

   // Bit positions of each flag in the packed 4-bit {N,Z,C,V} word.
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Derives {N,Z,C,V} from an upstream ALU/shifter result.
// Latency: combinational.
// Backpressure: none.
// Ports: result_i (N bits), overflow_i, carry_i -> flags_o[3:0] = {N,Z,C,V}.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] result_i,
   input  logic         overflow_i,
   input  logic         carry_i,
   output logic [3:0]   flags_o
);

   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_N] = result_i[N-1];
      flags_o[FLAG_Z] = (result_i == '0);
      flags_o[FLAG_C] = carry_i;
      flags_o[FLAG_V] = overflow_i;
   end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer that attaches {N,Z,C,V} flags at push time.
// Latency: 1 cycle from push to out_valid when empty.
// Backpressure: in_ready drops when both entries are held; outputs hold while out_ready is low.
//
// Ports:
//   clk, rst                      - clock, async active-high reset
//   in_valid/in_ready             - upstream handshake; in_result, in_overflow, in_carry payload
//   out_valid/out_ready           - downstream handshake; out_result, out_flags {N,Z,C,V}
//   clr_sticky, sticky_v          - sticky overflow clear / indicator
// Build option: STICKY_OVF_EN enables the sticky overflow latch; otherwise sticky_v is tied low.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_result,
   input  logic         in_overflow,
   input  logic         in_carry,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [3:0]   out_flags,
   input  logic         clr_sticky,
   output logic         sticky_v
);

   state_t       state_q, state_d;
   logic [N-1:0] head_res_q, head_res_d;
   logic [N-1:0] tail_res_q, tail_res_d;
   alu_flags_t   head_flg_q, head_flg_d;
   alu_flags_t   tail_flg_q, tail_flg_d;
   logic [3:0]   new_flags_raw;
   alu_flags_t   new_flags;
   logic         push;
   logic         pop;

   alu_flag_gen #(.N(N)) u_flag_gen (
      .result_i   (in_result),
      .overflow_i (in_overflow),
      .carry_i    (in_carry),
      .flags_o    (new_flags_raw)
   );

   assign new_flags = alu_flags_t'(new_flags_raw);

   // Handshake signals come from registered state only, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Head is always the entry on the output; tail only exists in FULL.
   always_comb begin
      state_d    = state_q;
      head_res_d = head_res_q;
      head_flg_d = head_flg_q;
      tail_res_d = tail_res_q;
      tail_flg_d = tail_flg_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               state_d    = ST_ONE;
               head_res_d = in_result;
               head_flg_d = new_flags;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               // Head leaves and the new result replaces it in the same cycle.
               head_res_d = in_result;
               head_flg_d = new_flags;
            end else if (push) begin
               state_d    = ST_FULL;
               tail_res_d = in_result;
               tail_flg_d = new_flags;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               state_d    = ST_ONE;
               head_res_d = tail_res_q;
               head_flg_d = tail_flg_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         head_res_q <= '0;
         head_flg_q <= '0;
         tail_res_q <= '0;
         tail_flg_q <= '0;
      end else begin
         state_q    <= state_d;
         head_res_q <= head_res_d;
         head_flg_q <= head_flg_d;
         tail_res_q <= tail_res_d;
         tail_flg_q <= tail_flg_d;
      end
   end

   // Stale head contents are masked so an empty stage always shows zeros.
   assign out_result = out_valid ? head_res_q : '0;
   assign out_flags  = out_valid ? head_flg_q : 4'b0000;

`ifdef STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // A popped overflow wins over a simultaneous clear so no event is lost.
   always_comb begin
      sticky_d = sticky_q;
      if (pop && head_flg_q.v) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_v = sticky_q;
`else
   logic unused_clr_sticky;
   assign unused_clr_sticky = clr_sticky;
   assign sticky_v          = 1'b0;
`endif

endmodule
